// File: rtl/wave_analyzer.sv
// rtl/wave_analyzer.sv - period, peak/trough and shape measurement of a sample stream
module wave_analyzer #(
  parameter int DW     = 5,
  parameter int PW     = 8,
  parameter int THRESH = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          clear,
  output logic [PW-1:0] period,
  output logic [DW-1:0] wmax,
  output logic [DW-1:0] wmin,
  output logic [1:0]    shape,
  output logic          meas_valid,
  output logic          locked
);

  typedef enum logic [1:0] {IDLE, SEEK, MEAS} state_t;

  localparam logic [DW-1:0]      TH        = DW'(THRESH);
  localparam logic signed [DW:0] D_P1      = (DW+1)'(1);
  localparam logic signed [DW:0] D_M1      = (DW+1)'(-1);
  localparam logic signed [DW:0] D_P2      = (DW+1)'(2);
  localparam logic signed [DW:0] D_M2      = (DW+1)'(-2);
  localparam logic [1:0]         SH_SQUARE = 2'd0;
  localparam logic [1:0]         SH_SAW    = 2'd1;
  localparam logic [1:0]         SH_TRI    = 2'd2;
  localparam logic [1:0]         SH_UNK    = 2'd3;

  state_t        state;
  logic [DW-1:0] prev;
  logic [DW-1:0] run_max;
  logic [DW-1:0] run_min;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] n_up1;
  logic [PW-1:0] n_dn1;
  logic [PW-1:0] n_flat;
  logic [PW-1:0] n_jup;
  logic [PW-1:0] n_jdn;
  logic          ovf;
  logic          have_prev;

  logic signed [DW:0] delta;
  logic               crossing;
  logic [PW-1:0]      pcnt_nx;
  logic [PW-1:0]      up1_nx;
  logic [PW-1:0]      dn1_nx;
  logic [PW-1:0]      flat_nx;
  logic [PW-1:0]      jup_nx;
  logic [PW-1:0]      jdn_nx;
  logic               ovf_nx;
  logic [DW-1:0]      max_nx;
  logic [DW-1:0]      min_nx;
  logic [1:0]         shape_nx;
  logic               lock_nx;

  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v, input logic en);
    if (en && (v != '1)) return v + PW'(1);
    return v;
  endfunction

  // Window contents as they would be after counting the current sample
  always_comb begin
    delta    = $signed({1'b0, din}) - $signed({1'b0, prev});
    crossing = (prev < TH) && (din >= TH);
    pcnt_nx  = sat_inc(pcnt, 1'b1);
    ovf_nx   = ovf | (pcnt_nx == '1);
    up1_nx   = sat_inc(n_up1,  delta == D_P1);
    dn1_nx   = sat_inc(n_dn1,  delta == D_M1);
    flat_nx  = sat_inc(n_flat, delta == '0);
    jup_nx   = sat_inc(n_jup,  delta >= D_P2);
    jdn_nx   = sat_inc(n_jdn,  delta <= D_M2);
    max_nx   = (din > run_max) ? din : run_max;
    min_nx   = (din < run_min) ? din : run_min;
    if (ovf_nx)
      shape_nx = SH_UNK;
    else if ((up1_nx != '0) && (dn1_nx != '0) && (flat_nx == '0) && (jup_nx == '0) && (jdn_nx == '0))
      shape_nx = SH_TRI;
    else if ((up1_nx != '0) && (jdn_nx == PW'(1)) && (dn1_nx == '0) && (flat_nx == '0) && (jup_nx == '0))
      shape_nx = SH_SAW;
    else if ((jup_nx == PW'(1)) && (jdn_nx == PW'(1)) && (up1_nx == '0) && (dn1_nx == '0))
      shape_nx = SH_SQUARE;
    else
      shape_nx = SH_UNK;
    // the output registers still hold the previous measurement here
    lock_nx = have_prev && (pcnt_nx == period) && (shape_nx == shape) && (shape_nx != SH_UNK);
  end

  // Measurement FSM: idle -> seek first crossing -> measure crossing to crossing
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      run_max    <= '0;
      run_min    <= '0;
      pcnt       <= '0;
      n_up1      <= '0;
      n_dn1      <= '0;
      n_flat     <= '0;
      n_jup      <= '0;
      n_jdn      <= '0;
      ovf        <= 1'b0;
      have_prev  <= 1'b0;
      period     <= '0;
      wmax       <= '0;
      wmin       <= '0;
      shape      <= SH_UNK;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      prev       <= '0;
      run_max    <= '0;
      run_min    <= '0;
      pcnt       <= '0;
      n_up1      <= '0;
      n_dn1      <= '0;
      n_flat     <= '0;
      n_jup      <= '0;
      n_jdn      <= '0;
      ovf        <= 1'b0;
      have_prev  <= 1'b0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (din_valid) begin
        prev <= din;
        case (state)
          IDLE: state <= SEEK;
          SEEK: begin
            if (crossing) begin
              state   <= MEAS;
              pcnt    <= '0;
              n_up1   <= '0;
              n_dn1   <= '0;
              n_flat  <= '0;
              n_jup   <= '0;
              n_jdn   <= '0;
              ovf     <= 1'b0;
              run_max <= '0;
              run_min <= '1;
            end
          end
          MEAS: begin
            if (crossing) begin
              period     <= pcnt_nx;
              wmax       <= max_nx;
              wmin       <= min_nx;
              shape      <= shape_nx;
              locked     <= lock_nx;
              have_prev  <= 1'b1;
              meas_valid <= 1'b1;
              pcnt       <= '0;
              n_up1      <= '0;
              n_dn1      <= '0;
              n_flat     <= '0;
              n_jup      <= '0;
              n_jdn      <= '0;
              ovf        <= 1'b0;
              run_max    <= '0;
              run_min    <= '1;
            end else begin
              pcnt    <= pcnt_nx;
              n_up1   <= up1_nx;
              n_dn1   <= dn1_nx;
              n_flat  <= flat_nx;
              n_jup   <= jup_nx;
              n_jdn   <= jdn_nx;
              ovf     <= ovf_nx;
              run_max <= max_nx;
              run_min <= min_nx;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_analyzer.sv
// tb/tb_wave_analyzer.sv - self-checking bench for wave_analyzer
module tb_wave_analyzer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] din;
  logic       din_valid;
  logic       clear;
  logic [7:0] period;
  logic [4:0] wmax;
  logic [4:0] wmin;
  logic [1:0] shape;
  logic       meas_valid;
  logic       locked;

  always #5 clk = ~clk;

  wave_analyzer #(.DW(5), .PW(8), .THRESH(10)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .period(period), .wmax(wmax), .wmin(wmin), .shape(shape),
    .meas_valid(meas_valid), .locked(locked)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: history of accepted samples since restart, measured crossing to crossing
  int hist[$];
  int lc;
  bit have_prev;
  int e_per, e_max, e_min, e_shape, e_mv, e_lock;

  task automatic measure(input int n);
    int len, up1, dn1, flat, jup, jdn, mx, mn, dl, per, sh;
    len = n - 1 - lc;
    up1 = 0; dn1 = 0; flat = 0; jup = 0; jdn = 0; mx = 0; mn = 31;
    for (int j = lc + 1; j < n; j++) begin
      dl = hist[j] - hist[j-1];
      if (dl == 1) up1++;
      else if (dl == -1) dn1++;
      else if (dl == 0) flat++;
      else if (dl >= 2) jup++;
      else jdn++;
      if (hist[j] > mx) mx = hist[j];
      if (hist[j] < mn) mn = hist[j];
    end
    per = (len > 255) ? 255 : len;
    if (len >= 255) sh = 3;
    else if (up1 > 0 && dn1 > 0 && flat == 0 && jup == 0 && jdn == 0) sh = 2;
    else if (up1 > 0 && jdn == 1 && dn1 == 0 && flat == 0 && jup == 0) sh = 1;
    else if (jup == 1 && jdn == 1 && up1 == 0 && dn1 == 0) sh = 0;
    else sh = 3;
    e_lock    = (have_prev && per == e_per && sh == e_shape && sh != 3) ? 1 : 0;
    e_per     = per;
    e_max     = mx;
    e_min     = mn;
    e_shape   = sh;
    e_mv      = 1;
    have_prev = 1;
  endtask

  task automatic model(input int d, input bit v, input bit r, input bit c);
    int n;
    e_mv = 0;
    if (r || c) begin
      hist.delete();
      lc = -1;
      have_prev = 0;
      e_lock = 0;
      if (r) begin
        e_per = 0; e_max = 0; e_min = 0; e_shape = 3;
      end
    end else if (v) begin
      hist.push_back(d);
      n = hist.size();
      if (n >= 2 && hist[n-2] < 10 && hist[n-1] >= 10) begin
        if (lc >= 0) measure(n);
        repeat (n - 1) void'(hist.pop_front());
        lc = 0;
      end else if (lc < 0) begin
        while (hist.size() > 1) void'(hist.pop_front());
      end
    end
  endtask

  int m_per[$], m_max[$], m_min[$], m_shape[$], m_lock[$];

  task automatic clr_rec();
    m_per.delete(); m_max.delete(); m_min.delete(); m_shape.delete(); m_lock.delete();
  endtask

  task automatic step(input int d, input bit v, input bit r, input bit c);
    din = d[4:0]; din_valid = v; rst = r; clear = c;
    @(posedge clk);
    model(d, v, r, c);
    #1;
    chk("meas_valid", int'(meas_valid), e_mv);
    chk("period", int'(period), e_per);
    chk("wmax", int'(wmax), e_max);
    chk("wmin", int'(wmin), e_min);
    chk("shape", int'(shape), e_shape);
    chk("locked", int'(locked), e_lock);
    if (meas_valid === 1'b1) begin
      m_per.push_back(period); m_max.push_back(wmax); m_min.push_back(wmin);
      m_shape.push_back(shape); m_lock.push_back(locked);
    end
  endtask

  function automatic int gen(input int kind, input int hi, input int k);
    int p;
    if (kind == 0) return ((k % (hi + 10)) < hi) ? 20 : 0;
    if (kind == 1) return k % 21;
    p = k % 40;
    return (p <= 20) ? p : 40 - p;
  endfunction

  int kk;

  task automatic run_wave(input int kind, input int hi, input int pct, input int nsamp);
    int acc = 0;
    while (acc < nsamp) begin
      if ($urandom_range(99) < pct) begin
        step(gen(kind, hi, kk), 1, 0, 0);
        kk++;
        acc++;
      end else begin
        step($urandom_range(31), 0, 0, 0);
      end
    end
  endtask

  task automatic emit(input int val, input int cnt);
    repeat (cnt) step(val, 1, 0, 0);
  endtask

  task automatic do_reset();
    step(20, 1, 1, 1);
    step(0, 0, 1, 0);
    kk = 0;
    clr_rec();
  endtask

  function automatic int plen_of(input int kind, input int hi);
    if (kind == 0) return hi + 10;
    if (kind == 1) return 21;
    return 40;
  endfunction

  typedef struct {
    int kind; int hi; int pct;
    int per; int mx; int mn; int shp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int pl;
    int exp_sh[$], exp_lk[$], exp_pr[$];
    tbl[0] = '{kind:0, hi:10,  pct:100, per:20,  mx:20, mn:0, shp:0};
    tbl[1] = '{kind:1, hi:0,   pct:100, per:21,  mx:20, mn:0, shp:1};
    tbl[2] = '{kind:2, hi:0,   pct:100, per:40,  mx:20, mn:0, shp:2};
    tbl[3] = '{kind:2, hi:0,   pct:70,  per:40,  mx:20, mn:0, shp:2};
    tbl[4] = '{kind:0, hi:300, pct:100, per:255, mx:20, mn:0, shp:3};
    tbl[5] = '{kind:1, hi:0,   pct:60,  per:21,  mx:20, mn:0, shp:1};

    lc = -1; have_prev = 0;
    e_per = 0; e_max = 0; e_min = 0; e_shape = 3; e_mv = 0; e_lock = 0;
    din = '0; din_valid = 1'b0; clear = 1'b0; rst = 1'b1;
    do_reset();
    chk("reset_shape", int'(shape), 3);
    chk("reset_locked", int'(locked), 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      pl = plen_of(tbl[i].kind, tbl[i].hi);
      run_wave(tbl[i].kind, tbl[i].hi, tbl[i].pct, 4 * pl + pl / 2);
      chk("row_nmeas_ge3", (m_per.size() >= 3) ? 1 : 0, 1);
      if (m_per.size() >= 3) begin
        chk("row_period", m_per[0], tbl[i].per);
        chk("row_wmax", m_max[0], tbl[i].mx);
        chk("row_wmin", m_min[0], tbl[i].mn);
        chk("row_shape", m_shape[0], tbl[i].shp);
        chk("row_lock0", m_lock[0], 0);
        chk("row_lock1", m_lock[1], (tbl[i].shp != 3) ? 1 : 0);
        chk("row_lock2", m_lock[2], (tbl[i].shp != 3) ? 1 : 0);
      end
    end

    // Overlong square high phase saturates the period, then relocks
    do_reset();
    emit(0, 10); emit(20, 10); emit(0, 10); emit(20, 300); emit(0, 10);
    emit(20, 10); emit(0, 10); emit(20, 10); emit(0, 10); emit(20, 10);
    exp_pr = '{20, 255, 20, 20};
    exp_sh = '{0, 3, 0, 0};
    exp_lk = '{0, 0, 0, 1};
    chk("ovf_nmeas", m_per.size(), 4);
    if (m_per.size() == 4)
      for (int j = 0; j < 4; j++) begin
        chk("ovf_period", m_per[j], exp_pr[j]);
        chk("ovf_shape", m_shape[j], exp_sh[j]);
        chk("ovf_lock", m_lock[j], exp_lk[j]);
      end

    // Sawtooth switching to triangle in mid period
    do_reset();
    for (int k = 0; k < 100; k++) step(gen(1, 0, k), 1, 0, 0);
    for (int k = 30; k < 136; k++) step(gen(2, 0, k), 1, 0, 0);
    exp_sh = '{1, 1, 1, 1, 3, 2, 2};
    exp_lk = '{0, 1, 1, 1, 0, 0, 1};
    chk("switch_nmeas", m_per.size(), 7);
    if (m_per.size() == 7)
      for (int j = 0; j < 7; j++) begin
        chk("switch_shape", m_shape[j], exp_sh[j]);
        chk("switch_lock", m_lock[j], exp_lk[j]);
      end

    // rst and clear in the middle of a measurement window
    do_reset();
    run_wave(0, 10, 100, 65);
    chk("pre_rst_locked", int'(locked), 1);
    step(20, 1, 1, 0);
    chk("rst_period", int'(period), 0);
    chk("rst_shape", int'(shape), 3);
    clr_rec();
    run_wave(0, 10, 100, 60);
    chk("rst_nmeas", m_per.size(), 2);
    chk("pre_clr_locked", int'(locked), 1);
    step(gen(0, 10, kk), 1, 0, 1);
    chk("clr_period_held", int'(period), 20);
    chk("clr_shape_held", int'(shape), 0);
    chk("clr_locked", int'(locked), 0);
    clr_rec();
    run_wave(0, 10, 100, 60);
    chk("clr_nmeas", m_per.size(), 2);
    if (m_per.size() == 2) begin
      chk("clr_lock_first", m_lock[0], 0);
      chk("clr_lock_second", m_lock[1], 1);
    end

    // Randomized waves and raw noise with sporadic clear/rst against the model
    for (int r = 0; r < 8; r++) begin
      do_reset();
      kk = $urandom_range(100);
      run_wave($urandom_range(2), 10 + $urandom_range(20), 50 + $urandom_range(50), 300);
      for (int c = 0; c < 400; c++)
        step($urandom_range(31), $urandom_range(99) < 80, $urandom_range(999) == 0,
             $urandom_range(99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
